// File: rtl/dmem_lanes.sv
// Byte/half/word data memory with a valid/ready request channel and LAT-cycle access latency.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned or reserved-size accesses return resp_err_o and do not write.
module dmem_lanes #(
  parameter int    DEPTH     = 64,
  parameter int    LAT       = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic [31:0]   word_rd, wpos, ld_data;
  logic [3:0]    be;
  logic [7:0]    lane8;
  logic [15:0]   lane16;
  logic          mis, access;
  logic          unused_addr;

  assign unused_addr = ^req_addr_i[31:AW+2];
  assign idx         = addr_q[AW+1:2];
  assign word_rd     = mem_q[idx];
  assign access      = (state_q == WAIT) && (cnt_q == 8'd0);

  // Lane steering: store data is replicated across lanes and the byte enables pick the target.
  always_comb begin
    be      = 4'b0000;
    wpos    = wdata_q;
    ld_data = word_rd;
    lane8   = word_rd[{addr_q[1:0], 3'b000} +: 8];
    lane16  = addr_q[1] ? word_rd[31:16] : word_rd[15:0];
    case (size_q)
      2'b00: begin
        be      = 4'b0001 << addr_q[1:0];
        wpos    = {4{wdata_q[7:0]}};
        ld_data = {{24{sgn_q & lane8[7]}}, lane8};
      end
      2'b01: begin
        be      = addr_q[1] ? 4'b1100 : 4'b0011;
        wpos    = {2{wdata_q[15:0]}};
        ld_data = {{16{sgn_q & lane16[15]}}, lane16};
      end
      default: be = 4'b1111;
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = ((size_q == 2'b01) && addr_q[0]) ||
          ((size_q == 2'b10) && (addr_q[1:0] != 2'b00)) ||
          (size_q == 2'b11);
`else
    mis = 1'b0;
`endif
    if (mis) begin
      be      = 4'b0000;
      ld_data = 32'd0;
    end
  end

  // A reset in the commit cycle discards the store.
  always_ff @(posedge clk_i) begin
    if (!reset_i && access && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wpos[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          sgn_d   = req_signed_i;
          addr_d  = req_addr_i[AW+1:0];
          wdata_d = req_wdata_i;
          cnt_d   = 8'(LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          rdata_d = we_q ? 32'd0 : ld_data;
          err_d   = mis;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE) && !reset_i;
  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule
